down_count_checker: RTL and testbench

- Sequence checker placed directly downstream of the 2-bit synchronous down counter.
- Samples the counter's `q` every clock and checks that it follows the down sequence (3,2,1,0,3,… for WIDTH=2), or holds while the counter is disabled.
- Counts wrap-arounds and mismatches, and reports lock status.
- Used in-system as a health monitor and on the bench as a self-checking scoreboard for the counter.

---
 rtl/down_count_checker.sv | 106 ++++++++++
 tb/tb_down_count_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_count_checker.sv
// Down-sequence checker for a WIDTH-bit down counter.
// Tracks q_in against a prediction and counts wraps and mismatches.
module down_count_checker #(
  parameter int WIDTH  = 2,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [WIDTH-1:0]  q_in,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  expected
);

  typedef enum logic [1:0] {
    ACQUIRE,
    TRACK,
    MISS
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  prev_nx;
  logic [WIDTH-1:0]  pred;
  logic [WIDTH-1:0]  exp_nx;
  logic              locked_nx;
  logic              err_nx;
  logic [ERR_W-1:0]  ec_nx;
  logic [WRAP_W-1:0] wc_nx;
  logic              match;
  logic              wrap_hit;

  assign pred     = en ? prev - WIDTH'(1) : prev;
  assign match    = (q_in == pred);
  assign wrap_hit = en && (prev == '0) && (q_in == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACQUIRE;
      prev       <= '0;
      expected   <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      expected   <= exp_nx;
      locked     <= locked_nx;
      err        <= err_nx;
      err_count  <= ec_nx;
      wrap_count <= wc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACQUIRE: state_nx = TRACK;
      TRACK:   state_nx = match ? TRACK : MISS;
      MISS:    state_nx = match ? TRACK : MISS;
      default: state_nx = ACQUIRE;
    endcase
  end

  always_comb begin
    prev_nx   = q_in;
    locked_nx = locked;
    err_nx    = err;
    ec_nx     = err_count;
    wc_nx     = wrap_count;
    unique case (state)
      ACQUIRE: locked_nx = 1'b0;
      TRACK, MISS: begin
        if (match) begin
          locked_nx = 1'b1;
          if (wrap_hit && wrap_count != '1)
            wc_nx = wrap_count + WRAP_W'(1);
        end else begin
          locked_nx = 1'b0;
          if (state == TRACK)
            err_nx = 1'b1;
          if (err_count != '1)
            ec_nx = err_count + ERR_W'(1);
        end
      end
      default: locked_nx = 1'b0;
    endcase
    // clear wins over any same-cycle set or increment
    if (clr) begin
      err_nx = 1'b0;
      ec_nx  = '0;
      wc_nx  = '0;
    end
    exp_nx = en ? prev_nx - WIDTH'(1) : prev_nx;
  end

endmodule

// File: tb/tb_down_count_checker.sv
// Scoreboard bench for down_count_checker.
// A behavioural model pushes expected outputs per edge; DUT is compared after it.
module tb_down_count_checker;

  localparam int W    = 2;
  localparam int MASK = 3;
  localparam int WMAX = 255;
  localparam int EMAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] q_in = '0;
  logic       locked;
  logic       err;
  logic [3:0] err_count;
  logic [7:0] wrap_count;
  logic [1:0] expected;

  typedef struct {
    int l;
    int e;
    int ec;
    int wc;
    int ex;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int m_state = 0;
  int m_prev  = 0;
  int m_l     = 0;
  int m_e     = 0;
  int m_ec    = 0;
  int m_wc    = 0;
  int m_ex    = 0;

  down_count_checker #(.WIDTH(2), .WRAP_W(8), .ERR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .q_in       (q_in),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .expected   (expected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_prev  = 0;
    m_l     = 0;
    m_e     = 0;
    m_ec    = 0;
    m_wc    = 0;
    m_ex    = 0;
  endtask

  task automatic model_edge(input int e, input int q, input int c);
    int p;
    if (m_state == 0) begin
      m_state = 1;
      m_l = 0;
    end else begin
      p = e ? (m_prev + MASK) & MASK : m_prev;
      if (q == p) begin
        if (e != 0 && m_prev == 0 && q == MASK && m_wc < WMAX)
          m_wc++;
        m_l = 1;
        m_state = 1;
      end else begin
        if (m_state == 1)
          m_e = 1;
        if (m_ec < EMAX)
          m_ec++;
        m_l = 0;
        m_state = 2;
      end
    end
    m_prev = q;
    if (c != 0) begin
      m_e  = 0;
      m_ec = 0;
      m_wc = 0;
    end
    m_ex = e ? (m_prev + MASK) & MASK : m_prev;
  endtask

  task automatic compare_all(input exp_t x);
    check("locked", int'(locked), x.l);
    check("err", int'(err), x.e);
    check("err_count", int'(err_count), x.ec);
    check("wrap_count", int'(wrap_count), x.wc);
    check("expected", int'(expected), x.ex);
  endtask

  task automatic step(input int e, input int q, input int c = 0);
    exp_t x;
    en   = e[0];
    q_in = q[1:0];
    clr  = c[0];
    model_edge(e, q, c);
    x = '{m_l, m_e, m_ec, m_wc, m_ex};
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      x = sb.pop_front();
      compare_all(x);
    end
    clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_ec"}, int'(err_count), 0);
    check({tag, "_wc"}, int'(wrap_count), 0);
    check({tag, "_exp"}, int'(expected), 0);
  endtask

  initial begin
    int c;
    int q;
    int e;
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    step(1, 3);
    check("t1_acq_locked", int'(locked), 0);
    step(1, 2);
    check("t1_locked2", int'(locked), 1);
    check("t1_expected", int'(expected), 1);
    step(1, 1);
    step(1, 0);
    step(1, 3);
    check("t1_wrap", int'(wrap_count), 1);
    step(1, 2);
    check("t1_err", int'(err), 0);

    repeat (3) step(0, 2);
    step(1, 1);
    check("t2_locked", int'(locked), 1);
    check("t2_wrap", int'(wrap_count), 1);
    check("t2_err", int'(err), 0);

    step(1, 0);
    step(1, 3);
    step(1, 1);
    check("t3_err", int'(err), 1);
    check("t3_ec", int'(err_count), 1);
    check("t3_locked", int'(locked), 0);
    check("t3_state", int'(dut.state), 2);
    step(1, 0);
    check("t3_relock", int'(locked), 1);
    check("t3_sticky", int'(err), 1);

    step(1, 3);
    step(1, 0);
    step(1, 0);
    check("t4_ec", int'(err_count), 3);
    check("t4_locked", int'(locked), 0);
    step(1, 3);
    check("t4_relock", int'(locked), 1);

    step(1, 0, 1);
    check("t5_err", int'(err), 0);
    check("t5_ec", int'(err_count), 0);
    check("t5_locked", int'(locked), 0);
    check("t5_state", int'(dut.state), 2);
    step(1, 3);
    check("t5_relock", int'(locked), 1);

    c = 3;
    for (int i = 0; i < 1200; i++) begin
      c = (c + MASK) & MASK;
      step(1, c);
    end
    check("t6_wrap_sat", int'(wrap_count), 255);

    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_zero("midrst");
    check("midrst_state", int'(dut.state), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 2);
    check("acq_locked", int'(locked), 0);
    step(1, 1);
    check("acq_relock", int'(locked), 1);

    c = 1;
    for (int i = 0; i < 200; i++) begin
      e = int'($urandom_range(0, 1));
      if (e != 0)
        c = (c + MASK) & MASK;
      q = c;
      if ($urandom_range(0, 7) == 0)
        q = int'($urandom_range(0, 3));
      step(e, q, ($urandom_range(0, 31) == 0) ? 1 : 0);
    end

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
